// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the 5-stage MIPS pipeline fetch slice.
//               These are the next-PC source encodings driven by decode, the
//               NOP encoding used to fill squashed IF/ID slots, the default
//               reset PC, and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Next-PC source select, as encoded by the decode stage
    localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target (bpc)
    localparam logic [1:0] PCSRC_JR  = 2'b10;  // register target (da)
    localparam logic [1:0] PCSRC_J   = 2'b11;  // jump target (jpc)

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Default fetch address after reset
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Instruction fetches are always word aligned, so the low two bits of
    // any computed target are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_npc_sel.sv
`default_nettype none
// ============================================================================
// Module      : pipe_npc_sel
// Description : Combinational 4:1 next-PC select with word-alignment masking.
// Ports       : pcsource  in  2   select: 00 pc4, 01 bpc, 10 da, 11 jpc
//               pc4       in  32  sequential successor of the current pc
//               bpc       in  32  branch target
//               da        in  32  register (jr) target
//               jpc       in  32  jump target
//               npc       out 32  selected next PC, bits [1:0] forced to 0
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_npc_sel
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = pc4;
        unique case (pcsource)
            PCSRC_SEQ: w_raw = pc4;
            PCSRC_BR:  w_raw = bpc;
            PCSRC_JR:  w_raw = da;
            PCSRC_J:   w_raw = jpc;
            default:   w_raw = pc4;
        endcase
    end

    // A jr through a misaligned register value must still fetch a word.
    assign npc = word_align(w_raw);

endmodule : pipe_npc_sel
`default_nettype wire

// File: rtl/pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fetch
// Description : IF stage plus IF/ID pipeline register of the 5-stage MIPS
//               pipeline. Holds the PC, selects the next PC from decode's
//               redirect inputs, drives the instruction memory address and
//               captures inst/dpc4 for decode. Honours the load-use stall
//               (wpcir=0 holds everything) and squashes the fall-through
//               instruction on any taken redirect (no delay slot).
// Config      : FETCH_PERF_CNT_EN - when defined, adds saturating counters
//               perf_fetch, perf_stall and perf_squash as outputs.
// Ports       : clock       in  1   pipeline clock, rising edge
//               resetn      in  1   asynchronous active-low reset
//               pcsource    in  2   00 pc+4, 01 bpc, 10 da, 11 jpc
//               bpc/jpc/da  in  32  redirect targets from decode
//               wpcir       in  1   1 = advance, 0 = stall
//               imem_rdata  in  32  instruction at imem_addr (comb read)
//               imem_addr   out 32  = pc
//               pc, pc4     out 32  fetch PC and its successor
//               inst, dpc4  out 32  IF/ID contents for decode
//               dvalid      out 1   IF/ID holds a real instruction
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    input  logic        wpcir,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_squash
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_dpc4;
    logic        r_dvalid;

    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_redirect;
    logic        w_fetch;
    logic        w_squash;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = (pcsource != PCSRC_SEQ);
    // Decode's request is only honoured on a cycle it is not stalling.
    assign w_fetch    = wpcir && !w_redirect;
    assign w_squash   = wpcir &&  w_redirect;

    pipe_npc_sel u_npc_sel (
        .pcsource (pcsource),
        .pc4      (w_pc4),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .npc      (w_npc)
    );

    // PC register and IF/ID register share one enable: a stall freezes both,
    // so a redirect that arrives during a stall is simply seen again next
    // cycle because decode still holds the same instruction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc     <= RESET_PC;
            r_inst   <= NOP_INST;
            r_dpc4   <= 32'h0000_0000;
            r_dvalid <= 1'b0;
        end else if (wpcir) begin
            r_pc   <= w_npc;
            r_dpc4 <= w_pc4;
            if (w_redirect) begin
                // The word fetched this cycle is the wrong path.
                r_inst   <= NOP_INST;
                r_dvalid <= 1'b0;
            end else begin
                r_inst   <= imem_rdata;
                r_dvalid <= 1'b1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign inst      = r_inst;
    assign dpc4      = r_dpc4;
    assign dvalid    = r_dvalid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_squash;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_perf_fetch  <= 32'h0000_0000;
            r_perf_stall  <= 32'h0000_0000;
            r_perf_squash <= 32'h0000_0000;
        end else begin
            if (w_fetch && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (!wpcir && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_squash && (r_perf_squash != 32'hFFFF_FFFF)) begin
                r_perf_squash <= r_perf_squash + 32'd1;
            end
        end
    end

    assign perf_fetch  = r_perf_fetch;
    assign perf_stall  = r_perf_stall;
    assign perf_squash = r_perf_squash;
`else
    // Without the counters these qualifiers have no consumer.
    logic w_unused_perf;
    assign w_unused_perf = w_fetch ^ w_squash;
`endif

endmodule : pipe_fetch
`default_nettype wire

// File: tb/tb_pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_fetch
// Description : Directed self-checking bench for pipe_fetch. Instruction
//               memory returns 0x2001_0005 at address 0 and {0xAC00, addr[15:0]}
//               elsewhere, so every expected instruction is a fixed constant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] da;
    logic        wpcir;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] dpc4;
    logic        dvalid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_squash;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_fetch u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .da         (da),
        .wpcir      (wpcir),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .dpc4       (dpc4),
        .dvalid     (dvalid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_squash (perf_squash)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imem_rdata = (imem_addr == 32'h0) ? 32'h2001_0005
                                             : {16'hAC00, imem_addr[15:0]};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_inst, input logic [31:0] e_dpc4,
                            input logic e_dvalid);
        check({tag, ".pc"},     pc,                 e_pc);
        check({tag, ".inst"},   inst,               e_inst);
        check({tag, ".dpc4"},   dpc4,               e_dpc4);
        check({tag, ".dvalid"}, {31'b0, dvalid},    {31'b0, e_dvalid});
    endtask

    initial begin
        resetn   = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        da       = 32'h0;
        wpcir    = 1'b1;
        #12;
        // Reset state
        check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.imem_addr", imem_addr, 32'h0);
        check("reset.pc4",       pc4,       32'h4);

        @(negedge clock);
        resetn = 1'b1;

        // First fetch after release
        step();
        check_if("first", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
        step();
        check_if("seq8", 32'h8, 32'hAC00_0004, 32'h8, 1'b1);
        step();
        step();
        check_if("seq10", 32'h10, 32'hAC00_000C, 32'h10, 1'b1);

        // Branch taken at pc=0x10
        pcsource = 2'b01;
        bpc      = 32'h40;
        step();
        check_if("br", 32'h40, 32'h0, 32'h14, 1'b0);
        pcsource = 2'b00;
        step();
        check_if("br_tgt", 32'h44, 32'hAC00_0040, 32'h44, 1'b1);

        // Jump to 0x20, then stall three cycles there
        pcsource = 2'b11;
        jpc      = 32'h20;
        step();
        check_if("j20", 32'h20, 32'h0, 32'h48, 1'b0);
        pcsource = 2'b00;
        wpcir    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if($sformatf("stall%0d", i), 32'h20, 32'h0, 32'h48, 1'b0);
        end
        wpcir = 1'b1;
        step();
        check_if("resume", 32'h24, 32'hAC00_0020, 32'h24, 1'b1);

        // Stall and jump in the same cycle: stall wins
        wpcir    = 1'b0;
        pcsource = 2'b11;
        jpc      = 32'h100;
        step();
        check_if("stall_j", 32'h24, 32'hAC00_0020, 32'h24, 1'b1);
        wpcir = 1'b1;
        step();
        check_if("j100", 32'h100, 32'h0, 32'h28, 1'b0);

        // jr with misaligned register value
        pcsource = 2'b10;
        da       = 32'h0000_0083;
        step();
        check_if("jr", 32'h80, 32'h0, 32'h104, 1'b0);

        // Misaligned jump to the top word, then wrap
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFE;
        step();
        check_if("jtop", 32'hFFFF_FFFC, 32'h0, 32'h84, 1'b0);
        check("jtop.pc4", pc4, 32'h0);
        pcsource = 2'b00;
        step();
        check_if("wrap", 32'h0, 32'hAC00_FFFC, 32'h0, 1'b1);

        // Asynchronous reset during a pending redirect
        pcsource = 2'b01;
        bpc      = 32'h40;
        #2;
        resetn = 1'b0;
        #1;
        check_if("areset", 32'h0, 32'h0, 32'h0, 1'b0);
        pcsource = 2'b00;
        @(negedge clock);
        resetn = 1'b1;

        // 5 fetches, 2 stalls, 1 squash
        for (int i = 0; i < 5; i++) step();
        check_if("f5", 32'h14, 32'hAC00_0010, 32'h14, 1'b1);
        wpcir = 1'b0;
        step();
        step();
        check_if("s2", 32'h14, 32'hAC00_0010, 32'h14, 1'b1);
        wpcir    = 1'b1;
        pcsource = 2'b01;
        bpc      = 32'h200;
        step();
        check_if("sq1", 32'h200, 32'h0, 32'h18, 1'b0);
        pcsource = 2'b00;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch",  perf_fetch,  32'd5);
        check("perf_stall",  perf_stall,  32'd2);
        check("perf_squash", perf_squash, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("perf_fetch.rst",  perf_fetch,  32'd0);
        check("perf_stall.rst",  perf_stall,  32'd0);
        check("perf_squash.rst", perf_squash, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
`endif
        step();
        check("last.dvalid", {31'b0, dvalid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipe_fetch
`default_nettype wire
